// File: rtl/road_pkg.sv
// Shared constants and types for the road scroller.
package road_pkg;

    localparam int unsigned ROWS  = 32;
    localparam int unsigned ROW_H = 16;

    // Turn codes from the road generator; 2'b10 is reserved and treated as straight.
    localparam logic [1:0] TURN_STRAIGHT   = 2'b00;
    localparam logic [1:0] TURN_SOFT_RIGHT = 2'b01;
    localparam logic [1:0] TURN_SOFT_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StFetch,
        StWrite
    } state_e;

endpackage

// File: rtl/road_scroller_if.sv
// Frame/generator/lookup signal bundle between the road generator side and the scroller.
interface road_scroller_if;

    logic       startOfFrame;
    logic       run;
    logic [4:0] speed;
    logic [1:0] new_x_offset;
    logic       straight_ahead;
    logic       need_new_line;
    logic [9:0] pixelY;
    logic [9:0] road_left_x;
    logic       road_straight;
    logic [15:0] lines_consumed;

    modport master (
        output startOfFrame, run, speed, new_x_offset, straight_ahead, pixelY,
        input  need_new_line, road_left_x, road_straight, lines_consumed
    );

    modport slave (
        input  startOfFrame, run, speed, new_x_offset, straight_ahead, pixelY,
        output need_new_line, road_left_x, road_straight, lines_consumed
    );

endinterface

// File: rtl/road_edge_step.sv
// Next road edge from the current edge and a turn code, clamped to the legal range.
module road_edge_step
    import road_pkg::*;
#(
    parameter int unsigned X_STEP = 8,
    parameter int unsigned X_MIN  = 64,
    parameter int unsigned X_MAX  = 448
) (
    input  logic [9:0] x_old_i,
    input  logic [1:0] turn_i,
    output logic [9:0] x_new_o
);

    logic signed [11:0] x_sum;

    // Signed sum so a left step below zero still clamps to X_MIN.
    always_comb begin
        x_sum = $signed({2'b00, x_old_i});
        case (turn_i)
            TURN_SOFT_RIGHT: x_sum = x_sum + $signed(12'(X_STEP));
            TURN_SOFT_LEFT:  x_sum = x_sum - $signed(12'(X_STEP));
            default:         x_sum = $signed({2'b00, x_old_i});
        endcase
        if (x_sum < $signed(12'(X_MIN))) begin
            x_new_o = 10'(X_MIN);
        end else if (x_sum > $signed(12'(X_MAX))) begin
            x_new_o = 10'(X_MAX);
        end else begin
            x_new_o = x_sum[9:0];
        end
    end

endmodule

// File: rtl/road_scroller.sv
// Scrolling road-edge buffer: fetches new road lines per frame and serves per-line edge lookups.
module road_scroller
    import road_pkg::*;
#(
    parameter int unsigned ROWS   = road_pkg::ROWS,
    parameter int unsigned ROW_H  = road_pkg::ROW_H,
    parameter int unsigned X_INIT = 256,
    parameter int unsigned X_STEP = 8,
    parameter int unsigned X_MIN  = 64,
    parameter int unsigned X_MAX  = 448
) (
    input  logic          clk,
    input  logic          resetN,  // active-high despite the name
    road_scroller_if.slave bus
);

    localparam int unsigned HeadW = $clog2(ROWS);
    localparam int unsigned FineW = $clog2(ROW_H);

    state_e              state_q, state_d;
    logic [HeadW-1:0]    head_q, head_d;
    logic [FineW-1:0]    fine_q, fine_d;
    logic [1:0]          pend_q, pend_d;
    logic                frame_pend_q, frame_pend_d;
    logic [1:0]          turn_q, turn_d;
    logic                straight_q, straight_d;
    logic [15:0]         lines_q, lines_d;
    logic [9:0]          x_mem_q [ROWS];
    logic [ROWS-1:0]     s_mem_q;
    logic [9:0]          road_left_x_q;
    logic                road_straight_q;

    logic                wr_en;
    logic [HeadW-1:0]    wr_idx;
    logic [HeadW-1:0]    rd_idx;
    logic [10:0]         k_full;
    logic [FineW+1:0]    acc;
    logic [9:0]          x_new;

    assign wr_idx = head_q + HeadW'(1);

    road_edge_step #(
        .X_STEP (X_STEP),
        .X_MIN  (X_MIN),
        .X_MAX  (X_MAX)
    ) u_edge_step (
        .x_old_i (x_mem_q[head_q]),
        .turn_i  (turn_q),
        .x_new_o (x_new)
    );

    // Next-state logic: accumulate sub-row scroll, then fetch/write one line per whole row.
    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        fine_d       = fine_q;
        pend_d       = pend_q;
        frame_pend_d = frame_pend_q;
        turn_d       = turn_q;
        straight_d   = straight_q;
        lines_d      = lines_q;
        wr_en        = 1'b0;
        acc          = {2'b00, fine_q} + (FineW + 2)'(bus.speed);

        // A frame that arrives while busy is remembered once and replayed from idle.
        if (state_q != StIdle && bus.startOfFrame) begin
            frame_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                frame_pend_d = 1'b0;
                if (bus.run && (bus.startOfFrame || frame_pend_q)) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                fine_d  = acc[FineW-1:0];
                pend_d  = acc[FineW+1:FineW];
                state_d = (acc[FineW+1:FineW] != 2'd0) ? StFetch : StIdle;
            end
            StFetch: begin
                // Generator output is valid now; it advances on this request cycle.
                turn_d     = bus.new_x_offset;
                straight_d = bus.straight_ahead;
                state_d    = StWrite;
            end
            StWrite: begin
                wr_en   = 1'b1;
                head_d  = wr_idx;
                lines_d = (lines_q == 16'hFFFF) ? lines_q : lines_q + 16'd1;
                pend_d  = pend_q - 2'd1;
                state_d = (pend_q > 2'd1) ? StFetch : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q      <= StIdle;
            head_q       <= '0;
            fine_q       <= '0;
            pend_q       <= '0;
            frame_pend_q <= 1'b0;
            turn_q       <= TURN_STRAIGHT;
            straight_q   <= 1'b1;
            lines_q      <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            fine_q       <= fine_d;
            pend_q       <= pend_d;
            frame_pend_q <= frame_pend_d;
            turn_q       <= turn_d;
            straight_q   <= straight_d;
            lines_q      <= lines_d;
        end
    end

    // Road line buffer; entry after head receives the freshly fetched line.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            for (int i = 0; i < int'(ROWS); i++) begin
                x_mem_q[i] <= 10'(X_INIT);
            end
            s_mem_q <= '1;
        end else if (wr_en) begin
            x_mem_q[wr_idx] <= x_new;
            s_mem_q[wr_idx] <= straight_q;
        end
    end

    // Row index for the current screen line, counted back from the newest entry.
    always_comb begin
        k_full = 11'(bus.pixelY) + 11'(ROW_H) - 11'(fine_q);
        rd_idx = head_q - HeadW'(k_full >> FineW);
    end

    // Registered lookup; reads pre-edge buffer contents so a same-cycle write shows next time.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            road_left_x_q   <= 10'(X_INIT);
            road_straight_q <= 1'b1;
        end else begin
            road_left_x_q   <= x_mem_q[rd_idx];
            road_straight_q <= s_mem_q[rd_idx];
        end
    end

    assign bus.need_new_line  = (state_q == StFetch);
    assign bus.road_left_x    = road_left_x_q;
    assign bus.road_straight  = road_straight_q;
    assign bus.lines_consumed = lines_q;

endmodule

// File: tb/tb_road_scroller.sv
// Self-checking bench for road_scroller: directed sequences plus randomized frames
// checked against a queue-based model of the scrolling road.
module tb_road_scroller;

    logic clk = 1'b0;
    logic resetN;

    road_scroller_if rif ();

    road_scroller dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int py;
        int x;
        int s;
    } vec_t;

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int pulse_cnt = 0;
    int dbl_cnt   = 0;

    // Generator emulation controls.
    bit         gen_rand   = 1'b0;
    logic [1:0] fixed_code = 2'b00;
    logic       fixed_s    = 1'b1;
    bit         gen_prev   = 1'b0;
    bit         gen_adv    = 1'b0;
    logic [2:0] consumed_q[$];  // {code, straight} handed out on each request

    // Model: rows newest-first, scroll phase and fetched-line count.
    int m_x[$];
    int m_s[$];
    int m_fine;
    int m_lines;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_x.delete();
        m_s.delete();
        for (int i = 0; i < 32; i++) begin
            m_x.push_back(256);
            m_s.push_back(1);
        end
        m_fine  = 0;
        m_lines = 0;
    endtask

    function automatic int m_clamp(input int v);
        if (v < 64) return 64;
        if (v > 448) return 448;
        return v;
    endfunction

    // Fold every line the generator handed out into the model.
    task automatic m_absorb();
        logic [2:0] e;
        int nx;
        while (consumed_q.size() > 0) begin
            e  = consumed_q.pop_front();
            nx = m_x[0];
            if (e[2:1] == 2'b01) nx = nx + 8;
            else if (e[2:1] == 2'b11) nx = nx - 8;
            m_x.push_front(m_clamp(nx));
            m_s.push_front(int'(e[0]));
            void'(m_x.pop_back());
            void'(m_s.pop_back());
            if (m_lines < 65535) m_lines++;
        end
    endtask

    function automatic int m_row(input int py);
        return (py + 16 - m_fine) / 16;
    endfunction

    // Generator: hands out its current value on a request, advances afterwards.
    initial begin
        rif.new_x_offset   = 2'b00;
        rif.straight_ahead = 1'b1;
        forever begin
            @(negedge clk);
            if (rif.need_new_line === 1'b1) begin
                if (gen_prev) dbl_cnt++;
                pulse_cnt++;
                consumed_q.push_back({rif.new_x_offset, rif.straight_ahead});
                gen_adv = 1'b1;
            end else if (gen_rand) begin
                if (gen_adv) begin
                    rif.new_x_offset   = 2'($urandom);
                    rif.straight_ahead = 1'($urandom);
                    gen_adv = 1'b0;
                end
            end else begin
                rif.new_x_offset   = fixed_code;
                rif.straight_ahead = fixed_s;
            end
            gen_prev = (rif.need_new_line === 1'b1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rif.run          = 1'b0;
        rif.startOfFrame = 1'b0;
        resetN           = 1'b1;
        @(negedge clk);
        resetN = 1'b0;
        consumed_q.delete();
        m_reset();
    endtask

    // One frame pulse; optional speed change once the frame is already being fetched.
    task automatic run_frame(input bit r, input int spd, input int late_spd);
        int p0;
        int n;
        int acc;
        @(negedge clk);
        rif.run          = r;
        rif.speed        = 5'(spd);
        rif.startOfFrame = 1'b1;
        p0               = pulse_cnt;
        @(negedge clk);
        rif.startOfFrame = 1'b0;
        @(negedge clk);
        if (late_spd >= 0) rif.speed = 5'(late_spd);
        repeat (7) @(negedge clk);
        n = 0;
        if (r) begin
            acc    = m_fine + spd;
            n      = acc / 16;
            m_fine = acc % 16;
        end
        check("frame_pulses", 32'(pulse_cnt - p0), 32'(n));
        m_absorb();
        check("lines_consumed", 32'(rif.lines_consumed), 32'(m_lines));
    endtask

    task automatic look(input int py);
        int k;
        @(negedge clk);
        rif.pixelY = 10'(py);
        @(negedge clk);
        k = m_row(py);
        check($sformatf("lookup_x py=%0d", py), 32'(rif.road_left_x), 32'(m_x[k]));
        check($sformatf("lookup_s py=%0d", py), 32'(rif.road_straight), 32'(m_s[k]));
    endtask

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rif.need_new_line === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("fetch_seen_in_time", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   p0;
        bit   ok;

        resetN           = 1'b1;
        rif.startOfFrame = 1'b0;
        rif.run          = 1'b0;
        rif.speed        = 5'd0;
        rif.pixelY       = 10'd0;
        m_reset();

        // Reset values while reset is held.
        @(negedge clk);
        check("rst_need_new_line", 32'(rif.need_new_line), 32'd0);
        check("rst_road_left_x", 32'(rif.road_left_x), 32'd256);
        check("rst_road_straight", 32'(rif.road_straight), 32'd1);
        check("rst_lines_consumed", 32'(rif.lines_consumed), 32'd0);
        @(negedge clk);
        resetN = 1'b0;

        // Full-screen sweep after reset.
        for (int py = 0; py < 480; py++) tbl.push_back('{py, 256, 1});
        foreach (tbl[i]) begin
            @(negedge clk);
            rif.pixelY = 10'(tbl[i].py);
            @(negedge clk);
            check($sformatf("sweep_x py=%0d", tbl[i].py), 32'(rif.road_left_x), 32'(tbl[i].x));
            check($sformatf("sweep_s py=%0d", tbl[i].py), 32'(rif.road_straight), 32'(tbl[i].s));
        end

        // Soft right held, speed 16: one line per frame.
        fixed_code = 2'b01;
        fixed_s    = 1'b0;
        p0         = pulse_cnt;
        repeat (5) run_frame(1'b1, 16, -1);
        check("right5_pulses", 32'(pulse_cnt - p0), 32'd5);
        check("right5_lines", 32'(rif.lines_consumed), 32'd5);
        run_frame(1'b1, 1, -1);  // fine becomes 1 so line 0 maps to the newest row
        look(0);
        check("right5_newest_x", 32'(rif.road_left_x), 32'd296);
        check("right5_newest_s", 32'(rif.road_straight), 32'd0);
        look(1);
        check("right5_prev_x", 32'(rif.road_left_x), 32'd288);

        // Speed 31 from fine 0: one fetch, then two with a late speed change ignored.
        do_reset();
        fixed_code = 2'b01;
        fixed_s    = 1'b1;
        run_frame(1'b1, 31, -1);
        check("spd31_f1_lines", 32'(rif.lines_consumed), 32'd1);
        look(0);
        look(14);
        look(15);
        look(16);
        run_frame(1'b1, 31, 0);
        check("spd31_f2_lines", 32'(rif.lines_consumed), 32'd3);
        look(0);
        look(13);
        check("spd31_f2_py13_x", 32'(rif.road_left_x), 32'd280);
        look(14);
        check("spd31_f2_py14_x", 32'(rif.road_left_x), 32'd272);
        look(15);

        // Soft left held 30 lines clamps at X_MIN; reserved code leaves edge alone.
        do_reset();
        fixed_code = 2'b11;
        repeat (30) run_frame(1'b1, 16, -1);
        for (int py = 0; py < 480; py += 16) begin
            look(py);
            check($sformatf("left_floor py=%0d", py), 32'(rif.road_left_x >= 10'd64), 32'd1);
        end
        fixed_code = 2'b10;
        repeat (3) run_frame(1'b1, 16, -1);
        run_frame(1'b1, 1, -1);
        look(0);
        check("reserved_newest_x", 32'(rif.road_left_x), 32'd64);

        // Frame arriving during WRITE is replayed after returning to idle.
        do_reset();
        fixed_code = 2'b01;
        @(negedge clk);
        rif.run          = 1'b1;
        rif.speed        = 5'd16;
        rif.startOfFrame = 1'b1;
        p0               = pulse_cnt;
        @(negedge clk);
        rif.startOfFrame = 1'b0;
        wait_fetch(ok);
        @(negedge clk);
        rif.startOfFrame = 1'b1;
        @(negedge clk);
        rif.startOfFrame = 1'b0;
        repeat (10) @(negedge clk);
        check("pending_pulses", 32'(pulse_cnt - p0), 32'd2);
        m_fine = 0;
        m_absorb();
        check("pending_lines", 32'(rif.lines_consumed), 32'd2);
        look(0);
        look(16);

        // Frozen: ten frames with run low do nothing.
        p0 = pulse_cnt;
        repeat (10) run_frame(1'b0, 16, -1);
        check("frozen_pulses", 32'(pulse_cnt - p0), 32'd0);
        look(0);
        look(16);

        // Reset in the middle of a fetch aborts it.
        do_reset();
        fixed_code = 2'b01;
        repeat (2) run_frame(1'b1, 16, -1);
        @(negedge clk);
        rif.startOfFrame = 1'b1;
        @(negedge clk);
        rif.startOfFrame = 1'b0;
        wait_fetch(ok);
        #2;
        resetN = 1'b1;
        #1;
        check("abort_need_new_line", 32'(rif.need_new_line), 32'd0);
        check("abort_road_left_x", 32'(rif.road_left_x), 32'd256);
        check("abort_road_straight", 32'(rif.road_straight), 32'd1);
        check("abort_lines", 32'(rif.lines_consumed), 32'd0);
        @(negedge clk);
        resetN = 1'b0;
        rif.run = 1'b0;
        consumed_q.delete();
        m_reset();
        p0 = pulse_cnt;
        repeat (4) @(negedge clk);
        check("abort_no_more_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("abort_lines_after", 32'(rif.lines_consumed), 32'd0);
        look(0);
        look(479);

        // Randomized frames and lookups against the model.
        do_reset();
        gen_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            run_frame($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1);
            repeat (3) look(int'($urandom_range(0, 479)));
        end

        check("no_back_to_back_requests", 32'(dbl_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
